// File: rtl/qpi_dsm_pkg.sv
// DSM writer shared types, constants and line builders.
// Also carries the QPI CSR / TX1 / RX1 bundle types.
package qpi_dsm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_ID,
    WAIT_ID,
    READY,
    SEND_ST,
    WAIT_ST
  } dsm_state_e;

  localparam logic [3:0]  REQ_WRLINE      = 4'h2;
  localparam logic [31:0] DSM_AFU_ID_LINE = 32'd0;

  typedef struct packed {
    logic [63:0] afu_dsm_base;
    logic        afu_dsm_base_valid;
  } afu_csr_t;

  typedef struct packed {
    logic [3:0]  req_type;
    logic [31:0] address;
    logic [12:0] mdata;
  } tx_hdr_t;

  typedef struct packed {
    tx_hdr_t      header;
    logic         wrvalid;
    logic [511:0] data;
  } tx_c1_t;

  typedef struct packed {
    logic [3:0]  resp_type;
    logic [12:0] mdata;
  } rx_hdr_t;

  typedef struct packed {
    rx_hdr_t header;
    logic    wrvalid;
  } rx_c1_t;

  function automatic logic [511:0] build_id_line(
    input logic [127:0] id
  );
    logic [511:0] l;
    l = '0;
    l[127:0] = id;
    return l;
  endfunction

  function automatic logic [511:0] build_status_line(
    input logic [63:0] s
  );
    logic [511:0] l;
    l = '0;
    l[63:0] = s;
    l[64] = 1'b1;
    return l;
  endfunction

endpackage

// File: rtl/qpi_dsm_status_writer_addr_gen.sv
// DSM line address: base line plus offset, wrapping at 2^32.
// Purely combinational.
module qpi_dsm_addr_gen
  import qpi_dsm_pkg::*;
(
  input  logic [31:0] base_line,
  input  logic [31:0] offset,
  output logic [31:0] line_addr
);

  assign line_addr = base_line + offset;

endmodule

// File: rtl/qpi_dsm_status_writer.sv
// DSM writer: ID line to DSM line 0, then status lines.
// QPI_DSM_WRITE_ACK_EN: wait for the write ack before moving on.
module qpi_dsm_status_writer
  import qpi_dsm_pkg::*;
#(
  parameter logic [127:0] AFU_ID             = 128'h0,
  parameter logic [31:0]  STATUS_LINE_OFFSET = 32'd1,
  parameter logic [12:0]  MDATA_TAG          = 13'h1D4
)(
  input  logic        clk,
  input  logic        reset,
  input  afu_csr_t    csr,
  output tx_c1_t      tx1,
  input  logic        tx1_almostfull,
  input  rx_c1_t      rx1,
  input  logic        status_valid,
  input  logic [63:0] status_data,
  output logic        status_ready,
  output logic        afu_id_written
);

  localparam logic [12:0] TAG_ID =
    {MDATA_TAG[12:1], 1'b0};
  localparam logic [12:0] TAG_ST =
    {MDATA_TAG[12:1], 1'b1};

  dsm_state_e  state;
  dsm_state_e  state_n;
  logic [63:0] st_data;
  logic [31:0] offset;
  logic [31:0] line_addr;
  logic        base_valid;
  logic        issue;
  logic        accept;
  tx_c1_t      tx_n;
  logic        id_n;

  assign base_valid = csr.afu_dsm_base_valid;
  assign accept = (state == READY) &&
                  status_valid && status_ready;
  assign issue = base_valid && !tx1_almostfull &&
                 ((state == SEND_ID) ||
                  (state == SEND_ST));
  assign offset = (state == SEND_ID) ?
                  DSM_AFU_ID_LINE : STATUS_LINE_OFFSET;

`ifdef QPI_DSM_WRITE_ACK_EN
  logic ack_id;
  logic ack_st;
  assign ack_id = rx1.wrvalid &&
                  (rx1.header.mdata == TAG_ID);
  assign ack_st = rx1.wrvalid &&
                  (rx1.header.mdata == TAG_ST);
`endif

  qpi_dsm_addr_gen u_addr (
    .base_line (csr.afu_dsm_base[37:6]),
    .offset    (offset),
    .line_addr (line_addr)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state; losing the DSM base aborts to IDLE
  always_comb begin
    state_n = state;
    if (!base_valid) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_n = SEND_ID;
`ifdef QPI_DSM_WRITE_ACK_EN
        SEND_ID: if (issue) state_n = WAIT_ID;
        WAIT_ID: if (ack_id) state_n = READY;
        SEND_ST: if (issue) state_n = WAIT_ST;
        WAIT_ST: if (ack_st) state_n = READY;
`else
        SEND_ID: if (issue) state_n = READY;
        SEND_ST: if (issue) state_n = READY;
`endif
        READY:   if (accept) state_n = SEND_ST;
        default: state_n = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs
  always_comb begin
    tx_n = tx1;
    tx_n.wrvalid = 1'b0;
    if (issue) begin
      tx_n.wrvalid = 1'b1;
      tx_n.header.req_type = REQ_WRLINE;
      tx_n.header.address = line_addr;
      if (state == SEND_ID) begin
        tx_n.header.mdata = TAG_ID;
        tx_n.data = build_id_line(AFU_ID);
      end else begin
        tx_n.header.mdata = TAG_ST;
        tx_n.data = build_status_line(st_data);
      end
    end
    id_n = afu_id_written;
    if (!base_valid) begin
      id_n = 1'b0;
`ifdef QPI_DSM_WRITE_ACK_EN
    end else if (state == WAIT_ID && ack_id) begin
`else
    end else if (state == SEND_ID && issue) begin
`endif
      id_n = 1'b1;
    end
  end

  // Status payload capture on handshake
  always_ff @(posedge clk) begin
    if (reset)       st_data <= '0;
    else if (accept) st_data <= status_data;
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tx1            <= '0;
      status_ready   <= 1'b0;
      afu_id_written <= 1'b0;
    end else begin
      tx1            <= tx_n;
      status_ready   <= (state_n == READY);
      afu_id_written <= id_n;
    end
  end

endmodule

// File: tb/tb_qpi_dsm_status_writer.sv
// Directed bench for qpi_dsm_status_writer.
// Ack-specific steps follow QPI_DSM_WRITE_ACK_EN.
module tb_qpi_dsm_status_writer;
  import qpi_dsm_pkg::*;

  localparam logic [127:0] ID =
    128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic        clk = 1'b0;
  logic        reset;
  afu_csr_t    csr;
  tx_c1_t      tx1;
  logic        tx1_almostfull;
  rx_c1_t      rx1;
  logic        status_valid;
  logic [63:0] status_data;
  logic        status_ready;
  logic        afu_id_written;

  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  int consec = 0;
  logic prev_wv = 1'b0;

  always #5 clk = ~clk;

  qpi_dsm_status_writer #(
    .AFU_ID             (ID),
    .STATUS_LINE_OFFSET (32'd1),
    .MDATA_TAG          (13'h1D4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .csr            (csr),
    .tx1            (tx1),
    .tx1_almostfull (tx1_almostfull),
    .rx1            (rx1),
    .status_valid   (status_valid),
    .status_data    (status_data),
    .status_ready   (status_ready),
    .afu_id_written (afu_id_written)
  );

  always @(negedge clk) begin
    if (tx1.wrvalid) wr_count++;
    if (tx1.wrvalid && prev_wv) consec++;
    prev_wv = tx1.wrvalid;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wr(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!tx1.wrvalid && cyc < 20);
    if (!tx1.wrvalid) chk("wr_timeout", 64'(tx1.wrvalid), 1);
  endtask

  task automatic send_ack(input logic [12:0] tag);
    rx1.wrvalid = 1'b1;
    rx1.header.mdata = tag;
    step();
    rx1.wrvalid = 1'b0;
    rx1.header.mdata = '0;
  endtask

  task automatic chk_id_wr(input string tag,
                           input logic [31:0] a);
    chk({tag, "_addr"}, 64'(tx1.header.address), 64'(a));
    chk({tag, "_mdata"}, 64'(tx1.header.mdata), 64'h1D4);
    chk({tag, "_type"}, 64'(tx1.header.req_type), 64'h2);
    chk({tag, "_dlo"}, tx1.data[63:0], ID[63:0]);
    chk({tag, "_dhi"}, tx1.data[127:64], ID[127:64]);
    chk({tag, "_dz"}, 64'(|tx1.data[511:128]), 0);
  endtask

  task automatic chk_st_wr(input string tag,
                           input logic [31:0] a,
                           input logic [63:0] d);
    chk({tag, "_addr"}, 64'(tx1.header.address), 64'(a));
    chk({tag, "_mdata"}, 64'(tx1.header.mdata), 64'h1D5);
    chk({tag, "_d"}, tx1.data[63:0], d);
    chk({tag, "_flag"}, 64'(tx1.data[64]), 1);
    chk({tag, "_dz"}, 64'(|tx1.data[511:65]), 0);
  endtask

  // Drop base valid for a cycle so the FSM restarts
  task automatic drop_base();
    csr.afu_dsm_base_valid = 1'b0;
    step();
    chk("drop_idw", 64'(afu_id_written), 0);
    chk("drop_rdy", 64'(status_ready), 0);
  endtask

  // Offer a status word from READY; expect issue after accept
  task automatic status_wr(input string tag,
                           input logic [31:0] a,
                           input logic [63:0] d);
    int cyc;
    status_valid = 1'b1;
    status_data = d;
    wait_wr(cyc);
    status_valid = 1'b0;
    chk({tag, "_lat"}, 64'(cyc), 2);
    chk_st_wr(tag, a, d);
  endtask

  initial begin
    int cyc;
    int c0;
    reset = 1'b1;
    csr = '0;
    tx1_almostfull = 1'b0;
    rx1 = '0;
    status_valid = 1'b0;
    status_data = '0;
    step();
    step();
    chk("rst_wv", 64'(tx1.wrvalid), 0);
    chk("rst_addr", 64'(tx1.header.address), 0);
    chk("rst_hdr", 64'(tx1.header), 0);
    chk("rst_data", 64'(|tx1.data), 0);
    chk("rst_rdy", 64'(status_ready), 0);
    chk("rst_idw", 64'(afu_id_written), 0);

    // ID write, no back-pressure
    reset = 1'b0;
    csr.afu_dsm_base = 64'h0000_0001_2345_6780;
    csr.afu_dsm_base_valid = 1'b1;
    wait_wr(cyc);
    chk("id_lat", 64'(cyc), 2);
    chk_id_wr("id", 32'h048D_159E);
`ifdef QPI_DSM_WRITE_ACK_EN
    chk("id_idw_pre", 64'(afu_id_written), 0);
    repeat (4) step();
    chk("id_wait_rdy", 64'(status_ready), 0);
    send_ack(13'h1D4);
`endif
    chk("id_idw", 64'(afu_id_written), 1);
    step();
    chk("id_one_shot", 64'(tx1.wrvalid), 0);
    chk("id_rdy", 64'(status_ready), 1);

    // Status write to base+1
    status_valid = 1'b1;
    status_data = 64'hDEAD_BEEF_0000_0001;
    step();
    status_valid = 1'b0;
    chk("st_acc_rdy", 64'(status_ready), 0);
    wait_wr(cyc);
    chk("st_lat", 64'(cyc), 1);
    chk_st_wr("st", 32'h048D_159F, 64'hDEAD_BEEF_0000_0001);
`ifdef QPI_DSM_WRITE_ACK_EN
    chk("st_wait_rdy", 64'(status_ready), 0);
    repeat (3) step();
    chk("st_wait_rdy2", 64'(status_ready), 0);
    send_ack(13'h1D5);
`endif
    chk("st_rdy", 64'(status_ready), 1);
    status_wr("st2", 32'h048D_159F, 64'h0123_0000_A5A5_5A5A);

    // Back-pressure holds the ID write
    drop_base();
    c0 = wr_count;
    tx1_almostfull = 1'b1;
    csr.afu_dsm_base_valid = 1'b1;
    repeat (10) step();
    chk("bp_none", 64'(wr_count - c0), 0);
    tx1_almostfull = 1'b0;
    wait_wr(cyc);
    chk("bp_lat", 64'(cyc), 1);
    chk_id_wr("bp", 32'h048D_159E);
    repeat (4) step();
    chk("bp_once", 64'(wr_count - c0), 1);

    // Wrapping address, foreign ack ignored
    drop_base();
    csr.afu_dsm_base = 64'h0000_003F_FFFF_FFC0;
    csr.afu_dsm_base_valid = 1'b1;
    wait_wr(cyc);
    chk_id_wr("wr_id", 32'hFFFF_FFFF);
`ifdef QPI_DSM_WRITE_ACK_EN
    send_ack(13'h0005);
    chk("fa_idw", 64'(afu_id_written), 0);
    send_ack(13'h1D4);
`endif
    step();
    chk("wr_rdy", 64'(status_ready), 1);
    status_wr("wr_st", 32'h0000_0000, 64'h0000_0000_CAFE_F00D);
`ifdef QPI_DSM_WRITE_ACK_EN
    send_ack(13'h0005);
    chk("fa_rdy", 64'(status_ready), 0);
    send_ack(13'h1D5);
    chk("fa_rdy_ack", 64'(status_ready), 1);
`endif

    // Reset right after a status issue
    status_wr("rm_st", 32'h0000_0000, 64'h1111_2222_3333_4444);
    reset = 1'b1;
    step();
    chk("rm_wv", 64'(tx1.wrvalid), 0);
    chk("rm_hdr", 64'(tx1.header), 0);
    chk("rm_data", 64'(|tx1.data), 0);
    chk("rm_rdy", 64'(status_ready), 0);
    chk("rm_idw", 64'(afu_id_written), 0);
    reset = 1'b0;
    wait_wr(cyc);
    chk("rm_lat", 64'(cyc), 2);
    chk_id_wr("rm_id", 32'hFFFF_FFFF);
    step();
    chk("no_back2back", 64'(consec), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
